// File: rtl/demux_pkg.sv
// Shared defaults, the channel-select type and channel index constants
// for the four-way stream demultiplexer.
package demux_pkg;

    localparam int W_DEF     = 4;
    localparam int DEPTH_DEF = 2;
    localparam int N_CH      = 4;

    typedef logic [1:0] sel_t;

    localparam sel_t OP1 = 2'd0;
    localparam sel_t OP2 = 2'd1;
    localparam sel_t OP3 = 2'd2;
    localparam sel_t OP4 = 2'd3;

endpackage

// File: rtl/demux_fifo.sv
// Per-channel FIFO: power-of-two depth, wrapping pointers, occupancy counter.
// Head data reads as zero whenever the buffer is empty, so reset shows zero data.
module demux_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    // A pop request on an empty buffer is dropped, so there is no bypass path.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/demux_stream.sv
// Four-way stream demultiplexer: routes each input word into the FIFO of the
// channel chosen by in_sel; each channel drains independently.
module demux_stream
    import demux_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  sel_t         in_sel,
    output logic         op1_valid,
    input  logic         op1_ready,
    output logic [W-1:0] op1_data,
    output logic         op2_valid,
    input  logic         op2_ready,
    output logic [W-1:0] op2_data,
    output logic         op3_valid,
    input  logic         op3_ready,
    output logic [W-1:0] op3_data,
    output logic         op4_valid,
    input  logic         op4_ready,
    output logic [W-1:0] op4_data,
    output logic [3:0]   op_pend
);

    // Handshake: a word moves on a rising edge when valid && ready on that
    // link. in_ready depends only on in_sel and the selected buffer's full
    // flag (never on in_valid, never on a same-cycle pop), and is held low in reset.
    logic [N_CH-1:0] w_full;
    logic [N_CH-1:0] w_empty;
    logic [N_CH-1:0] w_push;
    logic [N_CH-1:0] w_pop_req;
    logic [W-1:0]    w_data [N_CH];

    assign in_ready  = rst_n && !w_full[in_sel];
    assign w_pop_req = {op4_ready, op3_ready, op2_ready, op1_ready};

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        assign w_push[ch] = in_valid && in_ready && (in_sel == sel_t'(ch));

        demux_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[ch]),
            .i_pop   (w_pop_req[ch]),
            .i_data  (in_data),
            .o_full  (w_full[ch]),
            .o_empty (w_empty[ch]),
            .o_data  (w_data[ch])
        );
    end

    assign op_pend   = ~w_empty;
    assign op1_valid = op_pend[OP1];
    assign op2_valid = op_pend[OP2];
    assign op3_valid = op_pend[OP3];
    assign op4_valid = op_pend[OP4];
    assign op1_data  = w_data[OP1];
    assign op2_data  = w_data[OP2];
    assign op3_data  = w_data[OP3];
    assign op4_data  = w_data[OP4];

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: directed vector table, reset/latency sequences and
// random traffic against a per-channel queue reference model.
module tb_demux_stream;
    import demux_pkg::*;

    localparam int W     = 4;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    sel_t         in_sel = '0;
    logic         op1_valid, op2_valid, op3_valid, op4_valid;
    logic [W-1:0] op1_data, op2_data, op3_data, op4_data;
    logic [3:0]   op_pend;
    logic [3:0]   op_ready_v = '0;
    logic [3:0]   op_valid_v;
    logic [W-1:0] op_data_v [4];

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q [4][$];

    always #5 clk = ~clk;

    demux_stream #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .op1_valid (op1_valid),
        .op1_ready (op_ready_v[0]),
        .op1_data  (op1_data),
        .op2_valid (op2_valid),
        .op2_ready (op_ready_v[1]),
        .op2_data  (op2_data),
        .op3_valid (op3_valid),
        .op3_ready (op_ready_v[2]),
        .op3_data  (op3_data),
        .op4_valid (op4_valid),
        .op4_ready (op_ready_v[3]),
        .op4_data  (op4_data),
        .op_pend   (op_pend)
    );

    assign op_valid_v   = {op4_valid, op3_valid, op2_valid, op1_valid};
    assign op_data_v[0] = op1_data;
    assign op_data_v[1] = op2_data;
    assign op_data_v[2] = op3_data;
    assign op_data_v[3] = op4_data;

    typedef struct packed {
        logic             valid;
        logic [1:0]       sel;
        logic [W-1:0]     data;
        logic [3:0]       ready;
        logic             exp_rdy;
        logic [3:0]       exp_pend;
        logic [3:0][W-1:0] exp_d;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                                input logic [3:0] r, input logic er, input logic [3:0] ep,
                                input logic [W-1:0] d4, input logic [W-1:0] d3,
                                input logic [W-1:0] d2, input logic [W-1:0] d1);
        vec_t t;
        t.valid    = v;
        t.sel      = s;
        t.data     = d;
        t.ready    = r;
        t.exp_rdy  = er;
        t.exp_pend = ep;
        t.exp_d    = {d4, d3, d2, d1};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, " op_pend"}, 32'(op_pend), 32'd0);
        chk({tag, " valid"}, 32'(op_valid_v), 32'd0);
        for (int c = 0; c < 4; c++) chk({tag, " data"}, 32'(op_data_v[c]), 32'd0);
    endtask

    initial begin
        // Columns: valid sel data ready | in_ready pend | op4 op3 op2 op1 head data
        vecs[0]  = mk(1, 2, 4'hA, 4'b0000, 1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[1]  = mk(0, 0, 4'h0, 4'b0100, 1, 4'b0100, 4'h0, 4'hA, 4'h0, 4'h0);
        vecs[2]  = mk(1, 0, 4'h1, 4'b0000, 1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[3]  = mk(1, 0, 4'h2, 4'b0000, 1, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h1);
        vecs[4]  = mk(1, 0, 4'h3, 4'b0000, 0, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h1);
        vecs[5]  = mk(1, 1, 4'h5, 4'b0000, 1, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h1);
        vecs[6]  = mk(1, 1, 4'h6, 4'b0010, 1, 4'b0011, 4'h0, 4'h0, 4'h5, 4'h1);
        vecs[7]  = mk(0, 0, 4'h0, 4'b0001, 0, 4'b0011, 4'h0, 4'h0, 4'h6, 4'h1);
        vecs[8]  = mk(1, 3, 4'hF, 4'b1001, 1, 4'b0011, 4'h0, 4'h0, 4'h6, 4'h2);
        vecs[9]  = mk(0, 0, 4'h0, 4'b0000, 1, 4'b1010, 4'hF, 4'h0, 4'h6, 4'h0);
        vecs[10] = mk(1, 1, 4'h7, 4'b1010, 1, 4'b1010, 4'hF, 4'h0, 4'h6, 4'h0);
        vecs[11] = mk(0, 1, 4'h0, 4'b0010, 1, 4'b0010, 4'h0, 4'h0, 4'h7, 4'h0);
        vecs[12] = mk(0, 0, 4'h0, 4'b0000, 1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Directed table; first push lands on the first edge after release
        for (int i = 0; i < 13; i++) begin
            in_valid   = vecs[i].valid;
            in_sel     = vecs[i].sel;
            in_data    = vecs[i].data;
            op_ready_v = vecs[i].ready;
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d op_pend", i), 32'(op_pend), 32'(vecs[i].exp_pend));
            chk($sformatf("vec%0d valid", i), 32'(op_valid_v), 32'(vecs[i].exp_pend));
            for (int c = 0; c < 4; c++)
                if (vecs[i].exp_pend[c])
                    chk($sformatf("vec%0d op%0d_data", i, c + 1), 32'(op_data_v[c]),
                        32'(vecs[i].exp_d[c]));
            @(posedge clk);
            #1;
        end

        // Fill every buffer, then drop reset between edges
        op_ready_v = '0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_sel   = sel_t'(i / 2);
            in_data  = W'(i + 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sel   = OP1;
        #2;
        chk("filled op_pend", 32'(op_pend), 32'hF);
        chk("filled in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        @(posedge clk);
        #1;
        chk_all_zero("held reset");

        // Release and accept on the very next edge
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_sel   = OP2;
        in_data  = 4'h9;
        @(negedge clk);
        chk("post-reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post-reset op_pend", 32'(op_pend), 32'b0010);
        chk("post-reset op2_data", 32'(op2_data), 32'h9);
        op_ready_v = 4'b0010;
        @(posedge clk);
        #1;
        op_ready_v = '0;
        chk("post-reset drained", 32'(op_pend), 32'd0);

        // Random traffic against the queue model
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            in_sel     = sel_t'($urandom_range(0, 3));
            in_data    = W'($urandom_range(0, 15));
            op_ready_v = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk("rnd in_ready", 32'(in_ready), 32'(exp_q[in_sel].size() < DEPTH));
            for (int c = 0; c < 4; c++) begin
                chk("rnd pend", 32'(op_pend[c]), 32'(exp_q[c].size() > 0));
                if (exp_q[c].size() > 0)
                    chk($sformatf("rnd op%0d_data", c + 1), 32'(op_data_v[c]), 32'(exp_q[c][0]));
            end
            begin
                logic acc;
                acc = in_valid && (exp_q[in_sel].size() < DEPTH);
                for (int c = 0; c < 4; c++)
                    if (op_ready_v[c] && exp_q[c].size() > 0) void'(exp_q[c].pop_front());
                if (acc) exp_q[in_sel].push_back(in_data);
            end
            @(posedge clk);
            #1;
        end

        // Drain remaining words in order
        in_valid   = 1'b0;
        op_ready_v = 4'hF;
        for (int k = 0; k < DEPTH + 1; k++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                chk("drain pend", 32'(op_pend[c]), 32'(exp_q[c].size() > 0));
                if (exp_q[c].size() > 0) begin
                    chk($sformatf("drain op%0d_data", c + 1), 32'(op_data_v[c]), 32'(exp_q[c][0]));
                    void'(exp_q[c].pop_front());
                end
            end
            @(posedge clk);
            #1;
        end
        chk("final op_pend", 32'(op_pend), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter W, default 4: data width of input and every output channel.
REQ-002 Parameter DEPTH, default 2: entries per output buffer, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block accepts input word this cycle.
REQ-007 in_data  input  W  input word.
REQ-008 in_sel  input  2  destination: 0->op1, 1->op2, 2->op3, 3->op4.
REQ-009 opN_valid  output  1  (N=1..4) channel N holds a word.
REQ-010 opN_ready  input  1  (N=1..4) channel N consumer takes word.
REQ-011 opN_data  output  W  (N=1..4) head word of channel N.
REQ-012 op_pend  output  4  bit N-1 = channel N buffer non-empty (equals opN_valid).

Function
REQ-013 The block SHALL accept a word when in_valid && in_ready at a rising edge, and push it into the buffer selected by in_sel.
REQ-014 in_ready SHALL be combinational: 1 iff the buffer selected by current in_sel is not full; it SHALL NOT depend on in_valid, nor take credit for a same-cycle pop.
REQ-015 Latency SHALL be exactly 1 cycle: an accepted word into an empty buffer appears on opN_data with opN_valid=1 the next cycle.
REQ-016 opN_data SHALL show the oldest entry of buffer N; opN_valid SHALL be 1 iff buffer N is non-empty.
REQ-017 A pop on channel N SHALL occur when opN_valid && opN_ready at a rising edge; opN_ready while opN_valid=0 SHALL have no effect.
REQ-018 Each buffer SHALL preserve arrival order; words on different channels have no mutual ordering.
REQ-019 Simultaneous push and pop on the same non-full, non-empty buffer SHALL leave occupancy unchanged and keep FIFO order.
REQ-020 Simultaneous push and pop on an empty buffer SHALL NOT bypass: the pop is ignored (valid was 0), the word is stored.
REQ-021 Buffer full (occupancy DEPTH) SHALL hold in_ready=0 for that sel; other channels SHALL remain independently writable.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter width SHALL be clog2(DEPTH)+1 and never exceed DEPTH or underflow.
REQ-023 opN_data and in_data SHALL NOT be altered by the block (no width conversion, no padding).
REQ-024 A change of in_sel while in_valid=1 and in_ready=0 SHALL be legal; in_ready re-evaluates for the new sel the same cycle.

Reset
REQ-025 While rst_n=0: all buffers empty, pointers and counters 0, opN_valid=0, op_pend=0, opN_data=0, in_ready=0.
REQ-026 Reset SHALL take effect immediately on rst_n falling, independent of clk, discarding any buffered words mid-operation.
REQ-027 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package demux_pkg SHALL hold W and DEPTH defaults, the 2-bit sel typedef, and channel index constants OP1..OP4.
REQ-029 One sub-module demux_fifo (W, DEPTH; push, pop, full, empty, head data) SHALL be instantiated four times; top holds only sel decode and in_ready mux.

Verification
REQ-030 Reset release, in_data=4'hA, in_sel=2, in_valid=1 one cycle, op3_ready=0 -> next cycle op3_valid=1, op3_data=4'hA, op_pend=4'b0100, others valid 0.
REQ-031 Push 4'h1,4'h2 to sel=0 with op1_ready=0 -> in_ready=0 for sel=0, in_ready=1 for sel=1; third push to sel=0 stalls; op1 later drains 4'h1 then 4'h2.
REQ-032 op2 holding one word (4'h5), push 4'h6 to sel=1 with op2_ready=1 same cycle -> next cycle op2_data=4'h6, occupancy 1.
REQ-033 Empty op4, push 4'hF with op4_ready=1 -> op4_valid=0 that cycle, op4_valid=1, op4_data=4'hF next cycle.
REQ-034 Fill all four buffers, assert rst_n=0 mid-cycle -> all opN_valid, op_pend, in_ready drop to 0 before next clk edge.
REQ-035 Random traffic, random readies, 10k cycles -> per-channel scoreboard order match, no loss, no duplication.
